cmd_scheduler: RTL and testbench
================================

# cmd_scheduler

Command-level scheduler for the SD host CMD line. It arbitrates between two command requesters: the host register interface and the auto-stop (CMD12) generator from the DAT path. It sequences the CMD physical-layer controller through its strobe/response/ack handshake and enforces a response timeout. It sits between the command registers and the CMD physical-layer control block, and it is the only agent that drives that block's control inputs.

## Interface
- TIMEOUT_CYCLES, 64: sd_clock cycles allowed in WAIT_RESP or WAIT_PHY_ACK before abort.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- sd_clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- req_host  in  1  host command request, level; held until gnt_host.
- host_index  in  6  host command index.
- host_arg  in  32  host command argument.
- host_resp_type  in  2  0 none, 1 48-bit, 2 136-bit, 3 reserved (treated as 1).
- req_auto  in  1  auto-stop request, level; held until gnt_auto.
- auto_arg  in  32  CMD12 argument; index is fixed at 12, response type 1.
- gnt_host / gnt_auto  out  1  1-cycle grant pulse.
- done_host / done_auto  out  1  1-cycle completion pulse to the granted requester.
- resp_out  out  136  captured response; holds until the next grant.
- resp_valid  out  1  response captured; holds until the next grant.
- timeout_err  out  1  last command timed out; holds until the next grant.
- phy_command  out  38  {index[5:0], arg[31:0]}; stable from ISSUE until DONE.
- phy_strobe  out  1  to phy strobe_in.
- phy_no_response  out  1  to phy no_response; high when the response type is none.
- phy_idle  out  1  to phy idle_in; 1-cycle abort.
- phy_ack  out  1  to phy ack_in.
- phy_strobe_in  in  1  phy strobe_out; response ready.
- phy_response  in  136  phy response bus.
- phy_ack_in  in  1  phy ack_out; handshake closed.

## Operation
- States: IDLE, ISSUE, WAIT_RESP, ACK, WAIT_PHY_ACK, DONE.
- IDLE, arbitration:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: round-robin using a last_grant bit. The reset value of last_grant is host, so auto wins the first tie.
  - Grant actions: pulse gnt_x, latch index/arg/type, clear resp_valid, timeout_err and resp_out, update last_grant, go to ISSUE.
- ISSUE: phy_strobe=1 for exactly one cycle; phy_no_response=(type==0) from this cycle until DONE; clear the counter; go to WAIT_RESP.
- WAIT_RESP, counter increments each cycle:
  - phy_strobe_in=1: capture resp_out from phy_response (zero if type 0); resp_valid=(type!=0); go to ACK.
  - Otherwise, counter==TIMEOUT_CYCLES-1: phy_idle=1 for one cycle, timeout_err=1, go to DONE.
- ACK: phy_ack=1 for one cycle; clear the counter; go to WAIT_PHY_ACK.
- WAIT_PHY_ACK: phy_ack_in=1 goes to DONE. Timeout is handled the same as in WAIT_RESP: phy_idle pulse and timeout_err=1; resp_out and resp_valid are kept.
- DONE: pulse done_x for the granted requester; go to IDLE.
- phy_strobe_in or phy_ack_in outside its waiting state is ignored.
- A request that drops before its grant is discarded. Requests arriving mid-command wait in IDLE.
- Reset asserted at any point: immediate return to IDLE. All outputs 0, last_grant=host, counter 0. No phy_idle pulse is issued; the phy is reset separately.

## Timing
- Reset value of every output is 0.
- Request high in IDLE at edge N: gnt at N+1, phy_strobe at N+2.
- phy_strobe_in seen at edge M: resp_out and resp_valid at M+1, phy_ack high during M+1.
- phy_ack_in at edge K: done_x at K+1, IDLE at K+2.
- Back-to-back: a second request can be granted 1 cycle after done_x.
- Timeout: phy_idle and timeout_err assert exactly TIMEOUT_CYCLES cycles after entering the wait state; done_x follows 1 cycle later.
- Simultaneous phy_strobe_in and timeout terminal count: response wins.

## Test plan
- Host CMD17, arg 0x0000_1000, type 1; phy returns strobe 5 cycles later with response 0xAB..CD -> gnt_host, one phy_strobe, resp_out=0xAB..CD, resp_valid=1, one phy_ack, done_host, timeout_err=0.
- req_host and req_auto both asserted from reset -> auto granted first; after its done, host granted at the next IDLE cycle; auto raised again ties and loses to host? No: last_grant=host, so the next tie goes to auto. Check alternation over 4 ties.
- Type 0 CMD0 -> phy_no_response=1 from ISSUE to DONE, resp_valid=0, resp_out=0.
- No phy_strobe_in with TIMEOUT_CYCLES=64 -> phy_idle pulse at cycle 64 of WAIT_RESP, timeout_err=1, done_host 1 cycle later; the next grant clears timeout_err.
- phy_strobe_in on the terminal-count cycle -> response captured, no timeout.
- reset low during WAIT_RESP -> all outputs 0 immediately; after release, a pending req_auto is granted normally.

Source files
------------

// File: rtl/cmd_scheduler_if.sv
// Bundle of the requester-side and phy-side signals of the SD CMD-line scheduler.
// The scheduler uses the slave modport; the environment (registers, DAT path, phy) uses master.
interface cmd_scheduler_if;
  logic         req_host;
  logic [5:0]   host_index;
  logic [31:0]  host_arg;
  logic [1:0]   host_resp_type;
  logic         req_auto;
  logic [31:0]  auto_arg;
  logic         gnt_host;
  logic         gnt_auto;
  logic         done_host;
  logic         done_auto;
  logic [135:0] resp_out;
  logic         resp_valid;
  logic         timeout_err;
  logic [37:0]  phy_command;
  logic         phy_strobe;
  logic         phy_no_response;
  logic         phy_idle;
  logic         phy_ack;
  logic         phy_strobe_in;
  logic [135:0] phy_response;
  logic         phy_ack_in;

  modport slave (
    input  req_host, host_index, host_arg, host_resp_type, req_auto, auto_arg,
           phy_strobe_in, phy_response, phy_ack_in,
    output gnt_host, gnt_auto, done_host, done_auto, resp_out, resp_valid, timeout_err,
           phy_command, phy_strobe, phy_no_response, phy_idle, phy_ack
  );

  modport master (
    output req_host, host_index, host_arg, host_resp_type, req_auto, auto_arg,
           phy_strobe_in, phy_response, phy_ack_in,
    input  gnt_host, gnt_auto, done_host, done_auto, resp_out, resp_valid, timeout_err,
           phy_command, phy_strobe, phy_no_response, phy_idle, phy_ack
  );
endinterface

// File: rtl/cmd_scheduler.sv
// SD host CMD-line scheduler: round-robin arbitration between host and auto-stop (CMD12)
// requesters, strobe/response/ack sequencing of the CMD phy, and response/ack timeouts.
module cmd_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic           sd_clock,
  input  logic           reset,
  cmd_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RESP, S_ACK, S_WAIT_PHY_ACK, S_DONE
  } state_e;

  typedef enum logic {
    GRANT_HOST = 1'b0,
    GRANT_AUTO = 1'b1
  } grant_e;

  localparam logic [5:0]       AUTO_INDEX = 6'd12;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  grant_e         last_grant_q, last_grant_d;   // also identifies the owner of the current command
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           gnt_host_q, gnt_host_d;
  logic           gnt_auto_q, gnt_auto_d;
  logic           done_host_q, done_host_d;
  logic           done_auto_q, done_auto_d;
  logic [135:0]   resp_q, resp_d;
  logic           resp_valid_q, resp_valid_d;
  logic           timeout_err_q, timeout_err_d;
  logic [37:0]    cmd_q, cmd_d;
  logic           strobe_q, strobe_d;
  logic           no_resp_q, no_resp_d;
  logic           idle_q, idle_d;
  logic           ack_q, ack_d;
  logic           pick_auto;
  logic           finish_cmd;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    gnt_host_d    = 1'b0;
    gnt_auto_d    = 1'b0;
    done_host_d   = 1'b0;
    done_auto_d   = 1'b0;
    resp_d        = resp_q;
    resp_valid_d  = resp_valid_q;
    timeout_err_d = timeout_err_q;
    cmd_d         = cmd_q;
    strobe_d      = 1'b0;
    no_resp_d     = no_resp_q;
    idle_d        = 1'b0;
    ack_d         = 1'b0;
    pick_auto     = 1'b0;
    finish_cmd    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_host || bus.req_auto) begin
          pick_auto = bus.req_auto && (!bus.req_host || last_grant_q == GRANT_HOST);
          if (pick_auto) begin
            gnt_auto_d   = 1'b1;
            cmd_d        = {AUTO_INDEX, bus.auto_arg};
            no_resp_d    = 1'b0;
            last_grant_d = GRANT_AUTO;
          end else begin
            gnt_host_d   = 1'b1;
            cmd_d        = {bus.host_index, bus.host_arg};
            no_resp_d    = (bus.host_resp_type == 2'd0);
            last_grant_d = GRANT_HOST;
          end
          resp_d        = '0;
          resp_valid_d  = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = S_ISSUE;
        end
      end

      S_ISSUE: begin
        strobe_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT_RESP;
      end

      // A set timeout_err marks the abort cycle that follows the phy_idle pulse.
      S_WAIT_RESP: begin
        if (timeout_err_q) begin
          finish_cmd = 1'b1;
        end else if (bus.phy_strobe_in) begin
          resp_d       = no_resp_q ? '0 : bus.phy_response;
          resp_valid_d = !no_resp_q;
          ack_d        = 1'b1;
          state_d      = S_ACK;
        end else if (cnt_q == CNT_LAST) begin
          idle_d        = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACK: begin
        cnt_d   = '0;
        state_d = S_WAIT_PHY_ACK;
      end

      S_WAIT_PHY_ACK: begin
        if (timeout_err_q || bus.phy_ack_in) begin
          finish_cmd = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          idle_d        = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        no_resp_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (finish_cmd) begin
      done_host_d = (last_grant_q == GRANT_HOST);
      done_auto_d = (last_grant_q == GRANT_AUTO);
      state_d     = S_DONE;
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously; the response
  // register is reset too because its value is visible on resp_out.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_HOST;
      cnt_q         <= '0;
      gnt_host_q    <= 1'b0;
      gnt_auto_q    <= 1'b0;
      done_host_q   <= 1'b0;
      done_auto_q   <= 1'b0;
      resp_q        <= '0;
      resp_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cmd_q         <= '0;
      strobe_q      <= 1'b0;
      no_resp_q     <= 1'b0;
      idle_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      gnt_host_q    <= gnt_host_d;
      gnt_auto_q    <= gnt_auto_d;
      done_host_q   <= done_host_d;
      done_auto_q   <= done_auto_d;
      resp_q        <= resp_d;
      resp_valid_q  <= resp_valid_d;
      timeout_err_q <= timeout_err_d;
      cmd_q         <= cmd_d;
      strobe_q      <= strobe_d;
      no_resp_q     <= no_resp_d;
      idle_q        <= idle_d;
      ack_q         <= ack_d;
    end
  end

  assign bus.gnt_host        = gnt_host_q;
  assign bus.gnt_auto        = gnt_auto_q;
  assign bus.done_host       = done_host_q;
  assign bus.done_auto       = done_auto_q;
  assign bus.resp_out        = resp_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.timeout_err     = timeout_err_q;
  assign bus.phy_command     = cmd_q;
  assign bus.phy_strobe      = strobe_q;
  assign bus.phy_no_response = no_resp_q;
  assign bus.phy_idle        = idle_q;
  assign bus.phy_ack         = ack_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed self-checking bench for cmd_scheduler: normal response, round-robin ties,
// no-response commands, both timeouts, terminal-count race and mid-command reset.
`timescale 1ns/1ps
module tb_cmd_scheduler;

  localparam int           TIMEOUT_CYCLES = 64;
  localparam logic [135:0] RESP_A = 136'hAB_0011_2233_4455_6677_8899_AABB_CCDD_EE_CD;
  localparam logic [135:0] RESP_B = 136'h55_1234_5678_9ABC_DEF0_0FED_CBA9_8765_43_21;

  logic sd_clock = 1'b0;
  logic reset    = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_strobe = 0;
  int   n_ack    = 0;
  int   n_idle   = 0;

  cmd_scheduler_if bus ();

  cmd_scheduler #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(8)) dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check(input string tag, input logic [135:0] observed, input logic [135:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge and tally phy pulses seen there.
  task automatic step();
    @(negedge sd_clock);
    if (bus.phy_strobe) n_strobe++;
    if (bus.phy_ack)    n_ack++;
    if (bus.phy_idle)   n_idle++;
  endtask

  task automatic wait_gnt(output int waited);
    waited = 0;
    while (!(bus.gnt_host || bus.gnt_auto) && waited < 8) begin
      step();
      waited++;
    end
  endtask

  task automatic wait_idle_pulse(output int waited);
    waited = 0;
    while (!bus.phy_idle && waited < TIMEOUT_CYCLES + 8) begin
      step();
      waited++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.gnt_host, bus.gnt_auto, bus.done_host, bus.done_auto, bus.resp_valid,
                bus.timeout_err, bus.phy_strobe, bus.phy_no_response, bus.phy_idle, bus.phy_ack}, '0);
    check(tag, bus.resp_out, '0);
    check(tag, bus.phy_command, '0);
  endtask

  // Entered on the falling edge where the grant is visible; ends where done is visible.
  task automatic serve(input string tag, input logic [135:0] resp, input logic is_auto);
    step();
    bus.phy_strobe_in = 1'b1;
    bus.phy_response  = resp;
    step();
    bus.phy_strobe_in = 1'b0;
    bus.phy_response  = '0;
    check(tag, {bus.phy_ack, bus.resp_valid}, 2'b11);
    bus.phy_ack_in = 1'b1;
    step();
    check(tag, {bus.done_auto, bus.done_host}, 2'b00);
    step();
    bus.phy_ack_in = 1'b0;
    check(tag, {bus.done_auto, bus.done_host}, is_auto ? 2'b10 : 2'b01);
  endtask

  initial begin
    int waited;
    int s0, a0, i0;

    bus.req_host = 1'b0;  bus.host_index = '0;  bus.host_arg = '0;  bus.host_resp_type = '0;
    bus.req_auto = 1'b0;  bus.auto_arg = '0;
    bus.phy_strobe_in = 1'b0;  bus.phy_response = '0;  bus.phy_ack_in = 1'b0;

    // Reset values
    step();
    step();
    check_all_zero("reset_outputs");
    reset = 1'b1;
    step();

    // Host CMD17, response 5 cycles after the strobe
    bus.req_host = 1'b1;  bus.host_index = 6'd17;  bus.host_arg = 32'h0000_1000;  bus.host_resp_type = 2'd1;
    step();
    check("cmd17_gnt", {bus.gnt_auto, bus.gnt_host, bus.phy_strobe, bus.phy_no_response}, 4'b0100);
    check("cmd17_command", bus.phy_command, {6'd17, 32'h0000_1000});
    bus.req_host = 1'b0;
    s0 = n_strobe;
    a0 = n_ack;
    step();
    check("cmd17_strobe", {bus.phy_strobe, bus.gnt_host}, 2'b10);
    repeat (4) step();
    bus.phy_strobe_in = 1'b1;
    bus.phy_response  = RESP_A;
    step();
    bus.phy_strobe_in = 1'b0;
    bus.phy_response  = '0;
    check("cmd17_resp", bus.resp_out, RESP_A);
    check("cmd17_ack", {bus.resp_valid, bus.phy_ack, bus.timeout_err, bus.done_host}, 4'b1100);
    step();
    bus.phy_ack_in = 1'b1;
    step();
    bus.phy_ack_in = 1'b0;
    check("cmd17_done", {bus.done_auto, bus.done_host, bus.timeout_err, bus.phy_idle}, 4'b0100);
    step();
    check("cmd17_hold", bus.resp_out, RESP_A);
    check("cmd17_pulses", {bus.done_host, bus.resp_valid, 8'(n_strobe - s0), 8'(n_ack - a0)},
          {1'b0, 1'b1, 8'd1, 8'd1});

    // Round-robin: both requests held from reset; auto wins the first tie
    reset = 1'b0;
    step();
    check_all_zero("tie_reset");
    bus.req_host = 1'b1;  bus.host_index = 6'd7;  bus.host_arg = 32'h0000_0077;  bus.host_resp_type = 2'd2;
    bus.req_auto = 1'b1;  bus.auto_arg = 32'h0001_0000;
    step();
    reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_gnt(waited);
      check("tie_gnt", {bus.gnt_auto, bus.gnt_host}, (t % 2 == 0) ? 2'b10 : 2'b01);
      check("tie_command", bus.phy_command,
            (t % 2 == 0) ? {6'd12, 32'h0001_0000} : {6'd7, 32'h0000_0077});
      check("tie_latency", 32'(waited), (t == 0) ? 32'd1 : 32'd2);
      if (t == 3) begin
        bus.req_host = 1'b0;
        bus.req_auto = 1'b0;
      end
      serve("tie_serve", RESP_B, (t % 2 == 0));
    end

    // CMD0 with no response: response bus ignored, no_response held ISSUE..DONE
    bus.req_host = 1'b1;  bus.host_index = 6'd0;  bus.host_arg = 32'h0;  bus.host_resp_type = 2'd0;
    wait_gnt(waited);
    bus.req_host = 1'b0;
    check("cmd0_issue", {bus.gnt_host, bus.phy_no_response}, 2'b11);
    step();
    check("cmd0_strobe", {bus.phy_strobe, bus.phy_no_response}, 2'b11);
    bus.phy_strobe_in = 1'b1;
    bus.phy_response  = RESP_B;
    step();
    bus.phy_strobe_in = 1'b0;
    bus.phy_response  = '0;
    check("cmd0_resp", bus.resp_out, '0);
    check("cmd0_ack", {bus.phy_ack, bus.resp_valid, bus.phy_no_response}, 3'b101);
    bus.phy_ack_in = 1'b1;
    step();
    step();
    bus.phy_ack_in = 1'b0;
    check("cmd0_done", {bus.done_host, bus.phy_no_response}, 2'b11);
    step();
    check("cmd0_after", {bus.done_host, bus.phy_no_response}, 2'b00);

    // Response timeout: phy_idle exactly TIMEOUT_CYCLES after entering WAIT_RESP
    bus.req_host = 1'b1;  bus.host_index = 6'd17;  bus.host_arg = 32'h0000_2000;  bus.host_resp_type = 2'd1;
    wait_gnt(waited);
    bus.req_host = 1'b0;
    check("tmo_gnt", bus.gnt_host, 1'b1);
    i0 = n_idle;
    step();
    wait_idle_pulse(waited);
    check("tmo_latency", 32'(waited), 32'(TIMEOUT_CYCLES));
    check("tmo_flags", {bus.phy_idle, bus.timeout_err, bus.done_host, bus.resp_valid}, 4'b1100);
    step();
    check("tmo_done", {bus.done_host, bus.phy_idle, bus.timeout_err, 8'(n_idle - i0)},
          {1'b1, 1'b0, 1'b1, 8'd1});

    // Response on the terminal-count cycle wins; next grant clears timeout_err
    bus.req_host = 1'b1;  bus.host_index = 6'd18;  bus.host_arg = 32'h0000_3000;  bus.host_resp_type = 2'd3;
    wait_gnt(waited);
    bus.req_host = 1'b0;
    check("race_gnt", {bus.gnt_host, bus.timeout_err, bus.resp_valid, bus.phy_no_response}, 4'b1000);
    i0 = n_idle;
    step();
    repeat (TIMEOUT_CYCLES - 1) step();
    bus.phy_strobe_in = 1'b1;
    bus.phy_response  = RESP_A;
    step();
    bus.phy_strobe_in = 1'b0;
    bus.phy_response  = '0;
    check("race_resp", {bus.resp_valid, bus.phy_ack, bus.timeout_err, bus.phy_idle}, 4'b1100);
    check("race_data", bus.resp_out, RESP_A);

    // Ack timeout: response is kept
    step();
    wait_idle_pulse(waited);
    check("acktmo_latency", 32'(waited), 32'(TIMEOUT_CYCLES));
    check("acktmo_flags", {bus.timeout_err, bus.resp_valid, bus.done_host, 8'(n_idle - i0)},
          {1'b1, 1'b1, 1'b0, 8'd1});
    check("acktmo_data", bus.resp_out, RESP_A);
    step();
    check("acktmo_done", {bus.done_host, bus.done_auto, bus.phy_idle}, 3'b100);

    // Reset during WAIT_RESP with a pending auto request
    bus.req_host = 1'b1;  bus.host_index = 6'd0;  bus.host_arg = 32'hDEAD_BEEF;  bus.host_resp_type = 2'd0;
    wait_gnt(waited);
    bus.req_host = 1'b0;
    step();
    step();
    check("rst_before", {bus.phy_no_response, bus.timeout_err}, 2'b10);
    bus.req_auto = 1'b1;
    bus.auto_arg = 32'h0000_0005;
    step();
    step();
    reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    i0 = n_idle;
    step();
    step();
    check("rst_no_idle", 32'(n_idle - i0), 32'd0);
    reset = 1'b1;
    wait_gnt(waited);
    check("rst_auto_gnt", {bus.gnt_auto, bus.gnt_host, 8'(waited)}, {1'b1, 1'b0, 8'd1});
    check("rst_auto_command", bus.phy_command, {6'd12, 32'h0000_0005});
    bus.req_auto = 1'b0;
    serve("rst_auto_serve", RESP_B, 1'b1);
    check("rst_auto_resp", bus.resp_out, RESP_B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
